// File: rtl/dff_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : dff_serial_tx
// Purpose  : Parallel-to-serial bit transmitter. Accepts a WIDTH-bit word over
//            a valid/ready handshake and emits one framed bit per clock:
//            a start bit (~IDLE_LEVEL), the data MSB-first, and a stop bit
//            (IDLE_LEVEL). A frame is exactly WIDTH+2 cycles long. An accept
//            during the stop bit chains the next frame with no idle gap.
//
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            din_data   - parallel word, sampled only on an accept edge
//            din_valid  - producer has a word on din_data
//            din_ready  - combinational; high in IDLE/STOP while rst is low
//            dout       - registered serial line
//            dout_frame - registered; high for start, data and stop cycles
//            done       - registered one-cycle pulse during the stop bit
//
// Revision : 1.0 - initial release
// ============================================================================
module dff_serial_tx #(
    parameter int WIDTH      = 8,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_data,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_frame,
    output logic             done
);

    // ------------------------------------------------------------------------
    // Elaboration-time guard: a frame needs at least two data bits so the
    // counter has a non-zero width.
    // ------------------------------------------------------------------------
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("dff_serial_tx: WIDTH must be >= 2");
        end
    endgenerate

    localparam int                c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SHIFT = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_dout;
    logic               w_dout_nxt;
    logic               r_frame;
    logic               w_frame_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_accept;

    // Ready only when the line is free for a new start bit next cycle; forced
    // low during reset so a colliding word is visibly refused.
    assign din_ready = ((r_state == S_IDLE) || (r_state == S_STOP)) && !rst;
    assign w_accept  = din_valid && din_ready;

    assign dout       = r_dout;
    assign dout_frame = r_frame;
    assign done       = r_done;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. The outputs are computed for the state
    // being entered, so after the edge the registered outputs match r_state.
    // Entering a SHIFT cycle, dout takes the current MSB and the register
    // shifts at the same edge, so the next MSB is ready for the following bit.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = IDLE_LEVEL;
        w_frame_nxt = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE, S_STOP: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shreg_nxt = din_data;
                    w_dout_nxt  = ~IDLE_LEVEL;
                    w_frame_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_START: begin
                w_state_nxt = S_SHIFT;
                w_cnt_nxt   = c_CNT_LOAD;
                w_dout_nxt  = r_shreg[WIDTH-1];
                w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                w_frame_nxt = 1'b1;
            end

            S_SHIFT: begin
                w_frame_nxt = 1'b1;
                if (r_cnt == c_CNT_ZERO) begin
                    // Last data bit is on the line now; stop bit follows.
                    w_state_nxt = S_STOP;
                    w_dout_nxt  = IDLE_LEVEL;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - c_CNT_ONE;
                    w_dout_nxt  = r_shreg[WIDTH-1];
                    w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers. Reset wins over a simultaneous accept, so a
    // word offered on a reset edge is dropped and an in-flight frame ends
    // without a done pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_dout  <= IDLE_LEVEL;
            r_frame <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_frame <= w_frame_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dff_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_serial_tx
// Purpose  : Directed self-checking bench for dff_serial_tx. Instance u0 uses
//            IDLE_LEVEL=0, instance u1 uses IDLE_LEVEL=1. Expected line values
//            are derived from the transmitted word by the bench itself.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_serial_tx;

    logic       clk;
    logic       rst;

    logic [7:0] d0_din_data;
    logic       d0_din_valid;
    logic       d0_din_ready;
    logic       d0_dout;
    logic       d0_dout_frame;
    logic       d0_done;

    logic [7:0] d1_din_data;
    logic       d1_din_valid;
    logic       d1_din_ready;
    logic       d1_dout;
    logic       d1_dout_frame;
    logic       d1_done;

    int checks;
    int errors;

    dff_serial_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) u0 (
        .clk        (clk),
        .rst        (rst),
        .din_data   (d0_din_data),
        .din_valid  (d0_din_valid),
        .din_ready  (d0_din_ready),
        .dout       (d0_dout),
        .dout_frame (d0_dout_frame),
        .done       (d0_done)
    );

    dff_serial_tx #(.WIDTH(8), .IDLE_LEVEL(1'b1)) u1 (
        .clk        (clk),
        .rst        (rst),
        .din_data   (d1_din_data),
        .din_valid  (d1_din_valid),
        .din_ready  (d1_din_ready),
        .dout       (d1_dout),
        .dout_frame (d1_dout_frame),
        .done       (d1_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Check one full frame starting in its START cycle; returns one cycle
    // after the stop bit. sel picks u1 (IDLE_LEVEL=1) or u0 (IDLE_LEVEL=0).
    task automatic expect_frame(input string tag, input bit sel, input logic [7:0] word);
        logic idle;
        logic exp_dout;
        idle = sel;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      exp_dout = ~idle;
            else if (i == 9) exp_dout = idle;
            else             exp_dout = word[8-i];
            check($sformatf("%s.dout[%0d]", tag, i),
                  sel ? d1_dout : d0_dout, exp_dout);
            check($sformatf("%s.frame[%0d]", tag, i),
                  sel ? d1_dout_frame : d0_dout_frame, 1'b1);
            check($sformatf("%s.done[%0d]", tag, i),
                  sel ? d1_done : d0_done, (i == 9) ? 1'b1 : 1'b0);
            check($sformatf("%s.ready[%0d]", tag, i),
                  sel ? d1_din_ready : d0_din_ready, (i == 9) ? 1'b1 : 1'b0);
            tick();
        end
    endtask

    task automatic expect_idle(input string tag, input bit sel);
        check({tag, ".dout"},  sel ? d1_dout : d0_dout, sel);
        check({tag, ".frame"}, sel ? d1_dout_frame : d0_dout_frame, 1'b0);
        check({tag, ".done"},  sel ? d1_done : d0_done, 1'b0);
        check({tag, ".ready"}, sel ? d1_din_ready : d0_din_ready, 1'b1);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        d0_din_data  = 8'h00;
        d0_din_valid = 1'b0;
        d1_din_data  = 8'h00;
        d1_din_valid = 1'b0;

        // ---- Reset state ----
        tick();
        tick();
        check("rst.dout0",  d0_dout, 1'b0);
        check("rst.frame0", d0_dout_frame, 1'b0);
        check("rst.done0",  d0_done, 1'b0);
        check("rst.ready0", d0_din_ready, 1'b0);
        check("rst.dout1",  d1_dout, 1'b1);
        check("rst.ready1", d1_din_ready, 1'b0);
        rst = 1'b0;
        #1;
        expect_idle("idle0", 1'b0);
        expect_idle("idle1", 1'b1);

        // ---- 1. Single word A5 ----
        d0_din_data  = 8'hA5;
        d0_din_valid = 1'b1;
        tick();
        d0_din_valid = 1'b0;
        expect_frame("single", 1'b0, 8'hA5);
        expect_idle("single.after", 1'b0);

        // ---- 2. Back-to-back A5 then 3C ----
        d0_din_data  = 8'hA5;
        d0_din_valid = 1'b1;
        tick();
        d0_din_data  = 8'h3C;
        expect_frame("b2b.a", 1'b0, 8'hA5);
        d0_din_valid = 1'b0;
        expect_frame("b2b.b", 1'b0, 8'h3C);
        expect_idle("b2b.after", 1'b0);

        // ---- 3. Busy hold: data changes to FF mid-frame ----
        d0_din_data  = 8'hA5;
        d0_din_valid = 1'b1;
        tick();
        d0_din_data  = 8'hFF;
        expect_frame("busy.a", 1'b0, 8'hA5);
        d0_din_valid = 1'b0;
        expect_frame("busy.b", 1'b0, 8'hFF);
        expect_idle("busy.after", 1'b0);

        // ---- 4. Reset at the 4th data bit of A5 ----
        d0_din_data  = 8'hA5;
        d0_din_valid = 1'b1;
        tick();
        d0_din_valid = 1'b0;
        check("abort.start", d0_dout, 1'b1);
        tick();
        tick();
        tick();
        tick();
        check("abort.bit4", d0_dout, 1'b0);
        check("abort.bit4frame", d0_dout_frame, 1'b1);
        rst = 1'b1;
        #1;
        check("abort.ready_in_rst", d0_din_ready, 1'b0);
        tick();
        check("abort.dout",  d0_dout, 1'b0);
        check("abort.frame", d0_dout_frame, 1'b0);
        check("abort.done",  d0_done, 1'b0);
        check("abort.ready", d0_din_ready, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("abort.nodone[%0d]", i), d0_done, 1'b0);
            check($sformatf("abort.noframe[%0d]", i), d0_dout_frame, 1'b0);
        end
        d0_din_data  = 8'h5A;
        d0_din_valid = 1'b1;
        tick();
        d0_din_valid = 1'b0;
        expect_frame("after_abort", 1'b0, 8'h5A);
        expect_idle("after_abort.idle", 1'b0);

        // ---- 5. Boundaries 00 / FF on both idle levels ----
        d0_din_data  = 8'h00;
        d0_din_valid = 1'b1;
        tick();
        d0_din_valid = 1'b0;
        expect_frame("zeros0", 1'b0, 8'h00);
        d0_din_data  = 8'hFF;
        d0_din_valid = 1'b1;
        tick();
        d0_din_valid = 1'b0;
        expect_frame("ones0", 1'b0, 8'hFF);

        d1_din_data  = 8'h00;
        d1_din_valid = 1'b1;
        tick();
        d1_din_data  = 8'hFF;
        expect_frame("zeros1", 1'b1, 8'h00);
        d1_din_valid = 1'b0;
        expect_frame("ones1", 1'b1, 8'hFF);
        expect_idle("idle1.after", 1'b1);

        // ---- 6. Reset collides with accept ----
        rst          = 1'b1;
        d0_din_data  = 8'hC3;
        d0_din_valid = 1'b1;
        d1_din_data  = 8'hC3;
        d1_din_valid = 1'b1;
        tick();
        rst          = 1'b0;
        d0_din_valid = 1'b0;
        d1_din_valid = 1'b0;
        #1;
        expect_idle("collide0", 1'b0);
        expect_idle("collide1", 1'b1);
        tick();
        expect_idle("collide0.next", 1'b0);
        expect_idle("collide1.next", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
